// File: rtl/datapath.sv
// Register/bus datapath for the 8-bit accumulator CPU: one bus driver per cycle, registers and RAM load on posedge.
// Optional macro DATAPATH_LOADER_EN adds a RAM program-loader port active while clear is held.
module datapath #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             pc_inc,
  input  logic             jmp,
  input  logic             pc_out,
  input  logic             acc_in,
  input  logic             acc_out,
  input  logic             mar_in,
  input  logic             alu_out,
  input  logic             add_sub,
  input  logic             alu0_and,
  input  logic             alu1_or,
  input  logic             xor_not,
  input  logic             ram_in,
  input  logic             ram_out,
  input  logic             br_in,
  input  logic             ir_in,
  input  logic             ir_out,
  input  logic             opr_in,
  input  logic             hlt_sig,
`ifdef DATAPATH_LOADER_EN
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [WIDTH-1:0] prog_data,
`endif
  output logic [3:0]       instruction,
  output logic [WIDTH-1:0] out_value,
  output logic             carry,
  output logic             zero,
  output logic             halted,
  output logic             bus_conflict,
  output logic [WIDTH-1:0] bus_value
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_NOT = 4'b1110;

  logic [AW-1:0]    pc_q, pc_d, mar_q, mar_d;
  logic [WIDTH-1:0] ir_q, ir_d, acc_q, acc_d, br_q, br_d, out_q, out_d;
  logic             carry_q, carry_d, zero_q, zero_d;
  logic             halted_q, halted_d, conflict_q, conflict_d;

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;

  logic [3:0]       alu_sel;
  logic [WIDTH:0]   alu_res;
  logic [2:0]       n_drv;
  logic [WIDTH-1:0] bus;

  // Bit WIDTH of the result is the adder carry-out; logic ops and unused codes leave it clear.
  function automatic logic [WIDTH:0] alu_f(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      default: return '0;
    endcase
  endfunction

  assign alu_sel = {alu1_or, alu0_and, xor_not, add_sub};
  assign alu_res = alu_f(alu_sel, acc_q, br_q);

  always_comb begin
    n_drv = 3'(pc_out) + 3'(ir_out) + 3'(ram_out) + 3'(acc_out) + 3'(alu_out);
    bus   = '0;
    if (alu_out)      bus = alu_res[WIDTH-1:0];
    else if (ram_out) bus = ram_q[mar_q];
    else if (acc_out) bus = acc_q;
    else if (ir_out)  bus = {{(WIDTH-4){1'b0}}, ir_q[3:0]};
    else if (pc_out)  bus = {{(WIDTH-AW){1'b0}}, pc_q};
  end

  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    br_d       = br_q;
    out_d      = out_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    halted_d   = halted_q;
    conflict_d = conflict_q;
    ram_we     = 1'b0;
    ram_waddr  = mar_q;
    ram_wdata  = bus;
    // A halted machine freezes all architectural state until clear.
    if (!halted_q) begin
      if (mar_in) mar_d = bus[AW-1:0];
      if (ir_in)  ir_d  = bus;
      if (acc_in) acc_d = bus;
      if (br_in)  br_d  = bus;
      if (opr_in) out_d = bus;
      if (jmp)         pc_d = bus[AW-1:0];
      else if (pc_inc) pc_d = pc_q + AW'(1);
      if (alu_out && acc_in) begin
        carry_d = alu_res[WIDTH];
        zero_d  = (alu_res[WIDTH-1:0] == '0);
      end
      if (hlt_sig)    halted_d   = 1'b1;
      if (n_drv > 3'd1) conflict_d = 1'b1;
      ram_we = ram_in;
    end
    if (clear) begin
      ram_we = 1'b0;
`ifdef DATAPATH_LOADER_EN
      ram_we    = prog_we;
      ram_waddr = prog_addr;
      ram_wdata = prog_data;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      br_q       <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      br_q       <= br_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      halted_q   <= halted_d;
      conflict_q <= conflict_d;
    end
  end

  // RAM contents survive clear.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign instruction  = ir_q[WIDTH-1:WIDTH-4];
  assign out_value    = out_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign halted       = halted_q;
  assign bus_conflict = conflict_q;
  assign bus_value    = bus;

endmodule
